core_mau_wb: RTL and testbench

Parametrised memory access unit for the i2d core. It turns one load or store request from the execute stage into a single Wishbone classic master cycle, including byte-lane steering, sign/zero extension, retry back-off, bus-timeout detection and flush abort. It supersedes the fixed 32-bit MAU. Data width, retry limit and timeout are parameters, and errors are reported as a fault code instead of being dropped.

---
 rtl/core_mau_wb.sv | 208 ++++++++++++++++++++
 tb/tb_core_mau_wb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mau_wb.sv
// Memory access unit: one load/store from execute becomes one Wishbone classic cycle (lane steering, extension, retry, timeout, flush).
// Latency 2 cycles zero-wait, +1 per wait state, +2 per retry; mau_req is sampled only in IDLE, so busy is the backpressure.
module core_mau_wb #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int RTY_MAX = 4,
    parameter int TMO     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mau_req,
    input  logic [3:0]        mau_op,
    input  logic [AW-1:0]     mau_addr,
    input  logic              mau_flush,
    input  logic [DW-1:0]     data_in,
    output logic [DW-1:0]     data_out,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [AW-1:0]     adr_o,
    input  logic [DW-1:0]     dat_i,
    input  logic              ack_i,
    output logic              cyc_o,
    input  logic              err_i,
    input  logic              rty_i,
    output logic [DW/8-1:0]   sel_o,
    output logic              we_o,
    output logic              stb_o,
    output logic [DW-1:0]     dat_o
);
    localparam int SW = DW / 8;
    localparam int OB = $clog2(SW);
    localparam logic [3:0] RTY_LIM = 4'(RTY_MAX);
    localparam logic [7:0] TMO_LIM = 8'(TMO);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF} state_t;

    state_t        state, state_n;
    logic [3:0]    op_q;
    logic [OB-1:0] off_q;
    logic [3:0]    rty_cnt;
    logic [7:0]    tmo_cnt;

    logic          set_done, set_fault, launch, load_upd;
    logic          cnt_clr, rty_inc, tmo_inc, tmo_clr;
    logic [1:0]    code_n;
    logic          req_bad;
    logic [SW-1:0] sel_base, sel_n;
    logic [DW-1:0] wdat_n, ld_sh, ld_res;
    logic          ld_sign;

    assign cyc_o = (state == S_BUS);
    assign stb_o = (state == S_BUS);
    assign busy  = (state != S_IDLE);

    // Size 11 only exists on a 64-bit bus.
    always_comb begin
        req_bad = 1'b0;
        case (mau_op[1:0])
            2'b01:   req_bad = mau_addr[0];
            2'b10:   req_bad = |mau_addr[1:0];
            2'b11:   req_bad = (DW == 32) || (|mau_addr[2:0]);
            default: req_bad = 1'b0;
        endcase
    end

    always_comb begin
        int m;
        sel_base = '1;
        case (mau_op[1:0])
            2'b00:   sel_base = SW'(1);
            2'b01:   sel_base = SW'(3);
            2'b10:   sel_base = SW'(15);
            default: sel_base = '1;
        endcase
        sel_n = sel_base << mau_addr[OB-1:0];
        m = ((1 << mau_op[1:0]) - 1) & (SW - 1);
        wdat_n = '0;
        for (int i = 0; i < SW; i++)
            wdat_n[8*i +: 8] = data_in[8*(i & m) +: 8];
    end

    // Right-align the addressed lanes, then fill above the access size.
    always_comb begin
        int nbits;
        ld_sh = dat_i >> {off_q, 3'b000};
        case (op_q[1:0])
            2'b00:   ld_sign = ld_sh[7];
            2'b01:   ld_sign = ld_sh[15];
            2'b10:   ld_sign = ld_sh[31];
            default: ld_sign = ld_sh[DW-1];
        endcase
        ld_sign = ld_sign & ~op_q[2];
        nbits = 8 << op_q[1:0];
        ld_res = '0;
        for (int i = 0; i < DW; i++)
            ld_res[i] = (i < nbits) ? ld_sh[i] : ld_sign;
    end

    always_comb begin
        state_n   = state;
        set_done  = 1'b0;
        set_fault = 1'b0;
        code_n    = fault_code;
        launch    = 1'b0;
        load_upd  = 1'b0;
        cnt_clr   = 1'b0;
        rty_inc   = 1'b0;
        tmo_inc   = 1'b0;
        tmo_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mau_req && !mau_flush) begin
                    cnt_clr = 1'b1;
                    if (req_bad) begin
                        set_fault = 1'b1;
                        code_n    = 2'b01;
                    end else begin
                        launch  = 1'b1;
                        state_n = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (mau_flush) begin
                    state_n = S_IDLE;
                end else if (err_i) begin
                    set_fault = 1'b1;
                    code_n    = 2'b10;
                    state_n   = S_IDLE;
                end else if (ack_i) begin
                    set_done = 1'b1;
                    load_upd = ~op_q[3];
                    state_n  = S_IDLE;
                end else if (rty_i) begin
                    if (rty_cnt + 4'd1 == RTY_LIM) begin
                        set_fault = 1'b1;
                        code_n    = 2'b11;
                        state_n   = S_IDLE;
                    end else begin
                        rty_inc = 1'b1;
                        state_n = S_BACKOFF;
                    end
                end else if (tmo_cnt + 8'd1 == TMO_LIM) begin
                    set_fault = 1'b1;
                    code_n    = 2'b11;
                    state_n   = S_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_BACKOFF: begin
                if (mau_flush) begin
                    state_n = S_IDLE;
                end else begin
                    tmo_clr = 1'b1;
                    state_n = S_BUS;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            data_out   <= '0;
            rty_cnt    <= '0;
            tmo_cnt    <= '0;
            op_q       <= '0;
            off_q      <= '0;
            adr_o      <= '0;
            sel_o      <= '0;
            we_o       <= 1'b0;
            dat_o      <= '0;
        end else begin
            done  <= set_done;
            fault <= set_fault;
            if (set_fault) fault_code <= code_n;
            if (cnt_clr) begin
                rty_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                if (rty_inc) rty_cnt <= rty_cnt + 4'd1;
                if (tmo_inc)      tmo_cnt <= tmo_cnt + 8'd1;
                else if (tmo_clr) tmo_cnt <= '0;
            end
            if (launch) begin
                op_q  <= mau_op;
                off_q <= mau_addr[OB-1:0];
                adr_o <= {mau_addr[AW-1:OB], {OB{1'b0}}};
                sel_o <= sel_n;
                we_o  <= mau_op[3];
                dat_o <= wdat_n;
            end
            if (load_upd) data_out <= ld_res;
        end
    end

endmodule

// File: tb/tb_core_mau_wb.sv
// Scoreboard bench for core_mau_wb: a 32-bit instance (RTY_MAX=2, TMO=8) and a 64-bit instance.
// Stimulus pushes expected responses; per-instance monitors pop on done/fault or at the expected cycle.
module tb_core_mau_wb;
    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_FLT  = 2;

    typedef struct {
        string       nm;
        int          kind;
        logic [1:0]  code;
        logic [63:0] data;
        int          cyc;
        int          bchk;
        logic [63:0] adr;
        logic [7:0]  sel;
        logic        we;
        logic [63:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t qa[$];
    exp_t qb[$];
    int   sa[$];
    int   sb[$];

    logic        a_req = 0, a_flush = 0;
    logic [3:0]  a_op = 0;
    logic [31:0] a_addr = 0, a_din = 0, a_dati = 0;
    logic [31:0] a_dout, a_adr, a_dato;
    logic        a_busy, a_done, a_fault, a_cyc, a_stb, a_we;
    logic [1:0]  a_code;
    logic [3:0]  a_sel;
    logic        a_ack = 0, a_err = 0, a_rty = 0;

    logic        b_req = 0, b_flush = 0;
    logic [3:0]  b_op = 0;
    logic [31:0] b_addr = 0, b_adr;
    logic [63:0] b_din = 0, b_dati = 0, b_dout, b_dato;
    logic        b_busy, b_done, b_fault, b_cyc, b_stb, b_we;
    logic [1:0]  b_code;
    logic [7:0]  b_sel;
    logic        b_ack = 0, b_err = 0, b_rty = 0;

    core_mau_wb #(.DW(32), .AW(32), .RTY_MAX(2), .TMO(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .mau_req(a_req), .mau_op(a_op), .mau_addr(a_addr),
        .mau_flush(a_flush), .data_in(a_din), .data_out(a_dout), .busy(a_busy),
        .done(a_done), .fault(a_fault), .fault_code(a_code), .adr_o(a_adr), .dat_i(a_dati),
        .ack_i(a_ack), .cyc_o(a_cyc), .err_i(a_err), .rty_i(a_rty), .sel_o(a_sel),
        .we_o(a_we), .stb_o(a_stb), .dat_o(a_dato)
    );

    core_mau_wb #(.DW(64), .AW(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .mau_req(b_req), .mau_op(b_op), .mau_addr(b_addr),
        .mau_flush(b_flush), .data_in(b_din), .data_out(b_dout), .busy(b_busy),
        .done(b_done), .fault(b_fault), .fault_code(b_code), .adr_o(b_adr), .dat_i(b_dati),
        .ack_i(b_ack), .cyc_o(b_cyc), .err_i(b_err), .rty_i(b_rty), .sel_o(b_sel),
        .we_o(b_we), .stb_o(b_stb), .dat_o(b_dato)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h, expected %h (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    task automatic mon(input bit have, input exp_t e, input logic dn, input logic ft,
                       input logic [1:0] fc, input logic [63:0] dout, input logic cy, input logic st,
                       input logic bz, input logic [63:0] adr, input logic [7:0] sel, input logic we,
                       input logic [63:0] dat, output bit pop);
        pop = 1'b0;
        chk("invariant", "done_and_fault", 64'(dn & ft), 64'd0);
        chk("invariant", "busy_with_pulse", 64'(bz & (dn | ft)), 64'd0);
        if (have && cy) begin
            if (e.bchk == 1) begin
                chk(e.nm, "adr_o", adr, e.adr);
                chk(e.nm, "sel_o", 64'(sel), 64'(e.sel));
                chk(e.nm, "we_o", 64'(we), 64'(e.we));
                chk(e.nm, "dat_o", dat, e.dat);
                chk(e.nm, "stb_busy", 64'({st, bz}), 64'd3);
            end else if (e.bchk == 2) begin
                chk(e.nm, "no_bus", 64'(cy), 64'd0);
            end
        end
        if (dn || ft) begin
            if (!have) begin
                chk("unexpected", "pulse", 64'({dn, ft}), 64'd0);
            end else begin
                pop = 1'b1;
                chk(e.nm, "kind", 64'(ft ? K_FLT : K_DONE), 64'(e.kind));
                chk(e.nm, "cycle", 64'(cyc), 64'(e.cyc));
                if (ft) chk(e.nm, "fault_code", 64'(fc), 64'(e.code));
                chk(e.nm, "data_out", dout, e.data);
            end
        end else if (have && e.kind == K_NONE && cyc == e.cyc) begin
            pop = 1'b1;
            chk(e.nm, "cyc_dropped", 64'(cy), 64'd0);
            chk(e.nm, "data_out", dout, e.data);
        end else if (have && cyc > e.cyc) begin
            pop = 1'b1;
            chk(e.nm, "timeout", 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   have, pop;
        have = (qa.size() > 0);
        if (have) e = qa[0];
        mon(have, e, a_done, a_fault, a_code, 64'(a_dout), a_cyc, a_stb, a_busy,
            64'(a_adr), 8'(a_sel), a_we, 64'(a_dato), pop);
        if (pop) void'(qa.pop_front());
    end

    always @(negedge clk) begin
        exp_t e;
        bit   have, pop;
        have = (qb.size() > 0);
        if (have) e = qb[0];
        mon(have, e, b_done, b_fault, b_code, b_dout, b_cyc, b_stb, b_busy,
            64'(b_adr), b_sel, b_we, b_dato, pop);
        if (pop) void'(qb.pop_front());
    end

    // Scripted slaves: one response code per BUS cycle (0 none, 1 ack, 2 err, 3 rty, 4 err+ack).
    always @(negedge clk) begin
        int r;
        r = 0;
        if (a_cyc && sa.size() > 0) r = sa.pop_front();
        a_ack = (r == 1) || (r == 4);
        a_err = (r == 2) || (r == 4);
        a_rty = (r == 3);
    end

    always @(negedge clk) begin
        int r;
        r = 0;
        if (b_cyc && sb.size() > 0) r = sb.pop_front();
        b_ack = (r == 1) || (r == 4);
        b_err = (r == 2) || (r == 4);
        b_rty = (r == 3);
    end

    task automatic issue(input bit w64, input string nm, input logic [3:0] op, input logic [31:0] ad,
                         input logic [63:0] d, input logic fl, input int kind, input logic [1:0] code,
                         input logic [63:0] edata, input int lat, input int bchk,
                         input logic [63:0] eadr, input logic [7:0] esel, input logic [63:0] edat);
        exp_t e;
        @(negedge clk);
        if (!w64) begin
            a_req = 1'b1; a_op = op; a_addr = ad; a_din = d[31:0]; a_flush = fl;
        end else begin
            b_req = 1'b1; b_op = op; b_addr = ad; b_din = d; b_flush = fl;
        end
        e.nm = nm; e.kind = kind; e.code = code; e.data = edata; e.cyc = cyc + lat;
        e.bchk = bchk; e.adr = eadr; e.sel = esel; e.we = op[3]; e.dat = edat;
        if (!w64) qa.push_back(e);
        else      qb.push_back(e);
        @(negedge clk);
        a_req = 1'b0; a_flush = 1'b0; b_req = 1'b0; b_flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, "a_bus", 64'({a_cyc, a_stb, a_we, a_busy, a_done, a_fault}), 64'd0);
        chk(nm, "a_fault_code", 64'(a_code), 64'd0);
        chk(nm, "a_data_out", 64'(a_dout), 64'd0);
        chk(nm, "a_adr_sel_dat", {32'(a_adr) | a_dato, 32'(a_sel)}, 64'd0);
        chk(nm, "b_bus", 64'({b_cyc, b_stb, b_we, b_busy, b_done, b_fault, b_code}), 64'd0);
        chk(nm, "b_data_out", b_dout, 64'd0);
        chk(nm, "b_adr_sel_dat", b_dato | 64'(b_adr) | 64'(b_sel), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk_reset("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // signed byte load, two wait states
        a_dati = 32'h80AA55CC; sa = '{0, 0, 1};
        issue(0, "byte_ld", 4'b0000, 32'h1003, 0, 0, K_DONE, 2'b00, 64'hFFFFFF80, 4, 1, 64'h1000, 8'h8, 0);
        drain();
        // half store, upper data_in bits must not reach the bus
        sa = '{1};
        issue(0, "half_st", 4'b1001, 32'h2002, 64'hFFFF1234, 0, K_DONE, 2'b00, 64'hFFFFFF80, 2, 1, 64'h2000, 8'hC, 64'h12341234);
        drain();
        issue(0, "misalign", 4'b0010, 32'h3001, 0, 0, K_FLT, 2'b01, 64'hFFFFFF80, 1, 2, 0, 0, 0);
        drain();
        issue(0, "size11", 4'b0011, 32'h4000, 0, 0, K_FLT, 2'b01, 64'hFFFFFF80, 1, 2, 0, 0, 0);
        drain();
        sa = '{3, 3};
        issue(0, "rty_exh", 4'b0100, 32'h5001, 0, 0, K_FLT, 2'b11, 64'hFFFFFF80, 4, 1, 64'h5000, 8'h2, 0);
        drain();
        a_dati = 32'hBEEF1234; sa = '{3, 1};
        issue(0, "rty_ack", 4'b0101, 32'h6002, 0, 0, K_DONE, 2'b00, 64'h0000BEEF, 4, 1, 64'h6000, 8'hC, 0);
        drain();
        issue(0, "timeout", 4'b0010, 32'h7000, 64'h55667788, 0, K_FLT, 2'b11, 64'h0000BEEF, 9, 1, 64'h7000, 8'hF, 64'h55667788);
        drain();
        sa = '{4};
        issue(0, "err_ack", 4'b0010, 32'h8000, 0, 0, K_FLT, 2'b10, 64'h0000BEEF, 2, 1, 64'h8000, 8'hF, 0);
        drain();
        a_dati = 32'h12348001; sa = '{1};
        issue(0, "shalf_ld", 4'b0001, 32'h9000, 0, 0, K_DONE, 2'b00, 64'hFFFF8001, 2, 1, 64'h9000, 8'h3, 0);
        drain();
        sa = '{1};
        issue(0, "byte_st", 4'b1000, 32'h9002, 64'hA5, 0, K_DONE, 2'b00, 64'hFFFF8001, 2, 1, 64'h9000, 8'h4, 64'hA5A5A5A5);
        drain();

        // flush on the wait cycle that also carries an ack
        a_dati = 32'hDEADBEEF; sa = '{0, 1};
        issue(0, "flush_bus", 4'b0010, 32'hA004, 0, 0, K_NONE, 2'b00, 64'hFFFF8001, 3, 1, 64'hA004, 8'hF, 0);
        @(negedge clk);
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        drain();
        sa = '{1};
        issue(0, "flush_req", 4'b0010, 32'hA008, 0, 1, K_NONE, 2'b00, 64'hFFFF8001, 1, 2, 0, 0, 0);
        drain();
        chk("flush_req", "fault_code_held", 64'(a_code), 64'd2);

        b_dati = 64'h0123456789ABCDEF; sb = '{1};
        issue(1, "dword_ld", 4'b0011, 32'h108, 0, 0, K_DONE, 2'b00, 64'h0123456789ABCDEF, 2, 1, 64'h108, 8'hFF, 0);
        drain();
        sb = '{0, 1};
        issue(1, "b64_ld", 4'b0000, 32'h10B, 0, 0, K_DONE, 2'b00, 64'hFFFFFFFFFFFFFF89, 3, 1, 64'h108, 8'h08, 0);
        drain();
        sb = '{1};
        issue(1, "w64_st", 4'b1010, 32'h114, 64'hCAFEF00D, 0, K_DONE, 2'b00, 64'hFFFFFFFFFFFFFF89, 2, 1, 64'h110, 8'hF0, 64'hCAFEF00DCAFEF00D);
        drain();
        issue(1, "d64_mis", 4'b0011, 32'h10C, 0, 0, K_FLT, 2'b01, 64'hFFFFFFFFFFFFFF89, 1, 2, 0, 0, 0);
        drain();

        // reset while a silent bus cycle is in progress
        sa.delete();
        @(negedge clk);
        a_req = 1'b1; a_op = 4'b0010; a_addr = 32'hC000;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        chk("rst_in_bus", "cyc_before", 64'(a_cyc), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_in_bus");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sa = '{1};
        issue(0, "post_rst", 4'b0100, 32'hD000, 0, 0, K_DONE, 2'b00, 64'h000000EF, 2, 1, 64'hD000, 8'h1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
